// File: rtl/ring_stop_unit.sv
// Ring stop: registered pass-through slot, destination-ID ejection into a
// valid/ready register, and FIFO-buffered injection into empty ring slots.
module ring_stop_unit #(
    parameter int DATA_W    = 512,
    parameter int ADDR_W    = 36,
    parameter int ID_W      = 4,
    parameter int TYPE_W    = 3,
    parameter int NODE_ID   = 0,
    parameter int INJ_DEPTH = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   ring_in_valid,
    input  logic [ADDR_W+DATA_W+ID_W+TYPE_W-1:0]   ring_in_pkt,
    output logic                                   ring_out_valid,
    output logic [ADDR_W+DATA_W+ID_W+TYPE_W-1:0]   ring_out_pkt,
    input  logic                                   inj_valid,
    input  logic [ADDR_W+DATA_W+ID_W+TYPE_W-1:0]   inj_pkt,
    output logic                                   inj_ready,
    output logic                                   ej_valid,
    output logic [ADDR_W+DATA_W+ID_W+TYPE_W-1:0]   ej_pkt,
    input  logic                                   ej_ready,
    output logic [$clog2(INJ_DEPTH+1)-1:0]         inj_count
);

    localparam int PKT_W = ADDR_W + DATA_W + ID_W + TYPE_W;
    localparam int CNT_W = $clog2(INJ_DEPTH + 1);
    localparam int PTR_W = $clog2(INJ_DEPTH);
    localparam logic [ID_W-1:0] NODE_ID_L = ID_W'(NODE_ID);

    logic                 ring_valid_q, ring_valid_d;
    logic [PKT_W-1:0]     ring_pkt_q, ring_pkt_d;
    logic                 ej_valid_q, ej_valid_d;
    logic [PKT_W-1:0]     ej_pkt_q, ej_pkt_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [PKT_W-1:0]     fifo_mem [INJ_DEPTH];

    logic ej_free, match, capture, slot_free, push, pop;

    assign ej_free   = !ej_valid_q || ej_ready;
    assign match     = ring_in_valid && (ring_in_pkt[TYPE_W +: ID_W] == NODE_ID_L);
    assign capture   = match && ej_free;
    assign slot_free = !ring_in_valid || capture;
    assign inj_ready = (count_q < CNT_W'(INJ_DEPTH));
    assign push      = inj_valid && inj_ready;
    assign pop       = slot_free && (count_q != '0);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        ring_valid_d = ring_in_valid;
        ring_pkt_d   = ring_in_pkt;
        ej_valid_d   = ej_valid_q;
        ej_pkt_d     = ej_pkt_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;

        // Ring traffic wins; injection only fills an empty or just-ejected slot.
        if (pop) begin
            ring_valid_d = 1'b1;
            ring_pkt_d   = fifo_mem[rd_ptr_q];
            rd_ptr_d     = rd_ptr_q + 1'b1;
        end else if (capture) begin
            ring_valid_d = 1'b0;
        end

        if (capture) begin
            ej_valid_d = 1'b1;
            ej_pkt_d   = ring_in_pkt;
        end else if (ej_ready) begin
            ej_valid_d = 1'b0;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ring_valid_q <= 1'b0;
            ring_pkt_q   <= '0;
            ej_valid_q   <= 1'b0;
            ej_pkt_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            ring_valid_q <= ring_valid_d;
            ring_pkt_q   <= ring_pkt_d;
            ej_valid_q   <= ej_valid_d;
            ej_pkt_q     <= ej_pkt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; occupancy and pointers alone define valid entries.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= inj_pkt;
        end
    end

    assign ring_out_valid = ring_valid_q;
    assign ring_out_pkt   = ring_pkt_q;
    assign ej_valid       = ej_valid_q;
    assign ej_pkt         = ej_pkt_q;
    assign inj_count      = count_q;

endmodule

// File: tb/tb_ring_stop_unit.sv
// Self-checking bench for ring_stop_unit: directed steps plus a random phase,
// compared against a queue-based behavioural model of the stop.
module tb_ring_stop_unit;

    localparam int DATA_W    = 512;
    localparam int ADDR_W    = 36;
    localparam int ID_W      = 4;
    localparam int TYPE_W    = 3;
    localparam int NODE_ID   = 5;
    localparam int INJ_DEPTH = 4;
    localparam int PKT_W     = ADDR_W + DATA_W + ID_W + TYPE_W;
    localparam int CNT_W     = $clog2(INJ_DEPTH + 1);

    typedef logic [PKT_W-1:0] pkt_t;

    logic             clk, rst_n;
    logic             ring_in_valid, ring_out_valid;
    pkt_t             ring_in_pkt, ring_out_pkt;
    logic             inj_valid, inj_ready;
    pkt_t             inj_pkt;
    logic             ej_valid, ej_ready;
    pkt_t             ej_pkt;
    logic [CNT_W-1:0] inj_count;

    ring_stop_unit #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .TYPE_W(TYPE_W),
        .NODE_ID(NODE_ID), .INJ_DEPTH(INJ_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ring_in_valid(ring_in_valid), .ring_in_pkt(ring_in_pkt),
        .ring_out_valid(ring_out_valid), .ring_out_pkt(ring_out_pkt),
        .inj_valid(inj_valid), .inj_pkt(inj_pkt), .inj_ready(inj_ready),
        .ej_valid(ej_valid), .ej_pkt(ej_pkt), .ej_ready(ej_ready),
        .inj_count(inj_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   n_pass  = 0;
    int   n_total = 0;

    // Behavioural model: what the downstream slot, eject register and FIFO hold.
    logic m_ring_v;
    pkt_t m_ring_pkt;
    logic m_ej_v;
    pkt_t m_ej_pkt;
    pkt_t m_fifo [$];

    task automatic check(input string tag, input pkt_t obs, input pkt_t exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic pkt_t mk(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                                input int id, input logic [TYPE_W-1:0] ty);
        logic [ID_W-1:0] idv;
        idv = ID_W'(id);
        return {a, d, idv, ty};
    endfunction

    function automatic pkt_t rnd_pkt(input int id);
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
        return mk({4'($urandom), 32'($urandom)}, d, id, 3'($urandom));
    endfunction

    function automatic int other_id();
        int id;
        id = $urandom_range(0, (1 << ID_W) - 1);
        if (id == NODE_ID) id = NODE_ID + 1;
        return id;
    endfunction

    task automatic model_reset();
        m_ring_v = 1'b0; m_ring_pkt = '0;
        m_ej_v = 1'b0;   m_ej_pkt = '0;
        m_fifo.delete();
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".ring_v"}, pkt_t'(ring_out_valid), pkt_t'(m_ring_v));
        if (m_ring_v) check({tag, ".ring_pkt"}, ring_out_pkt, m_ring_pkt);
        check({tag, ".ej_v"}, pkt_t'(ej_valid), pkt_t'(m_ej_v));
        if (m_ej_v) check({tag, ".ej_pkt"}, ej_pkt, m_ej_pkt);
        check({tag, ".count"}, pkt_t'(inj_count), pkt_t'(m_fifo.size()));
        check({tag, ".ready"}, pkt_t'(inj_ready), pkt_t'(m_fifo.size() < INJ_DEPTH));
    endtask

    // One clock: drive inputs, advance the model by the stop's rules, compare after the edge.
    task automatic step(input string tag, input logic rv, input pkt_t rp,
                        input logic iv, input pkt_t ip, input logic er);
        logic is_mine, took, empty_slot, accepted;
        ring_in_valid = rv; ring_in_pkt = rp;
        inj_valid = iv;     inj_pkt = ip;
        ej_ready = er;

        is_mine    = rv && (int'(rp[TYPE_W +: ID_W]) == NODE_ID);
        took       = is_mine && (!m_ej_v || er);
        empty_slot = !rv || took;
        accepted   = iv && (m_fifo.size() < INJ_DEPTH);

        if (took) begin
            m_ej_v = 1'b1; m_ej_pkt = rp;
        end else if (er) begin
            m_ej_v = 1'b0;
        end

        if (empty_slot && m_fifo.size() > 0) begin
            m_ring_v = 1'b1; m_ring_pkt = m_fifo.pop_front();
        end else begin
            m_ring_v = rv && !took; m_ring_pkt = rp;
        end
        if (accepted) m_fifo.push_back(ip);

        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle(input string tag, input logic er);
        step(tag, 1'b0, '0, 1'b0, '0, er);
    endtask

    initial begin
        pkt_t p, q;
        rst_n = 1'b0;
        ring_in_valid = 1'b0; ring_in_pkt = '0;
        inj_valid = 1'b0;     inj_pkt = '0;
        ej_ready = 1'b0;
        model_reset();

        // Reset state
        #12;
        check("rst.ring_v", pkt_t'(ring_out_valid), '0);
        check("rst.ring_pkt", ring_out_pkt, '0);
        check("rst.ej_v", pkt_t'(ej_valid), '0);
        check("rst.ej_pkt", ej_pkt, '0);
        check("rst.count", pkt_t'(inj_count), '0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Pass-through, one-cycle latency
        p = mk(36'h123, '0, NODE_ID + 1, 3'd1);
        step("pass", 1'b1, p, 1'b0, '0, 1'b0);
        check("pass.pkt_literal", ring_out_pkt, p);
        idle("pass.idle", 1'b0);

        // Eject with backpressure: second match recirculates
        p = mk(36'hA, {16{32'h1111_0000}}, NODE_ID, 3'd2);
        q = mk(36'hB, {16{32'h2222_0000}}, NODE_ID, 3'd3);
        step("ej1", 1'b1, p, 1'b0, '0, 1'b0);
        step("ej2", 1'b1, q, 1'b0, '0, 1'b0);
        check("ej2.recirc", ring_out_pkt, q);
        check("ej2.held", ej_pkt, p);
        step("ej_rel", 1'b0, '0, 1'b0, '0, 1'b1);
        idle("ej_drop", 1'b0);

        // Fill FIFO while the ring is saturated with foreign traffic
        for (int i = 1; i <= 5; i++)
            step("fill", 1'b1, rnd_pkt(other_id()), 1'b1, mk('0, DATA_W'(i), other_id(), '0), 1'b0);
        check("fill.count4", pkt_t'(inj_count), pkt_t'(4));
        check("fill.notready", pkt_t'(inj_ready), '0);
        idle("gap1", 1'b0);
        check("gap1.data1", pkt_t'(ring_out_pkt[ID_W+TYPE_W +: DATA_W]), pkt_t'(1));
        idle("gap2", 1'b0);
        check("gap2.count2", pkt_t'(inj_count), pkt_t'(2));
        idle("gap3", 1'b0);

        // Eject and inject in the same slot
        step("ejinj", 1'b1, rnd_pkt(NODE_ID), 1'b0, '0, 1'b1);
        check("ejinj.ring_v", pkt_t'(ring_out_valid), pkt_t'(1));

        // Build count 2, then simultaneous push and pop
        step("c2a", 1'b1, rnd_pkt(other_id()), 1'b1, rnd_pkt(other_id()), 1'b1);
        step("c2b", 1'b1, rnd_pkt(other_id()), 1'b1, rnd_pkt(other_id()), 1'b1);
        step("pushpop", 1'b0, '0, 1'b1, rnd_pkt(other_id()), 1'b1);
        check("pushpop.count2", pkt_t'(inj_count), pkt_t'(2));

        // Pointer wrap across 3*INJ_DEPTH packets
        for (int i = 0; i < 3 * INJ_DEPTH; i++)
            step("wrap", 1'b0, '0, 1'b1, rnd_pkt($urandom_range(0, 15)), 1'b0);
        for (int i = 0; i < INJ_DEPTH; i++) idle("drain", 1'b1);

        // Asynchronous reset with FIFO holding 3 and an ejected packet held
        step("ar.ej", 1'b1, rnd_pkt(NODE_ID), 1'b0, '0, 1'b0);
        for (int i = 0; i < 3; i++)
            step("ar.fill", 1'b1, rnd_pkt(other_id()), 1'b1, rnd_pkt(other_id()), 1'b0);
        check("ar.pre_count", pkt_t'(inj_count), pkt_t'(3));
        check("ar.pre_ej", pkt_t'(ej_valid), pkt_t'(1));
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("ar.ring_v", pkt_t'(ring_out_valid), '0);
        check("ar.ring_pkt", ring_out_pkt, '0);
        check("ar.ej_v", pkt_t'(ej_valid), '0);
        check("ar.ej_pkt", ej_pkt, '0);
        check("ar.count", pkt_t'(inj_count), '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle("ar.after", 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic rv, iv, er;
            int   id;
            rv = ($urandom_range(0, 3) != 0);
            iv = $urandom_range(0, 1);
            er = ($urandom_range(0, 2) != 0);
            id = ($urandom_range(0, 2) == 0) ? NODE_ID : other_id();
            step("rnd", rv, rnd_pkt(id), iv, rnd_pkt($urandom_range(0, 15)), er);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ring_stop_unit.md
# ring_stop_unit

Parametrised, valid-qualified stop on the unidirectional packet ring. It replaces the unconditional-overwrite ring node with three behaviours: a registered pass-through slot, destination-ID ejection into a valid/ready output register, and a FIFO-buffered injection port that inserts local packets only into empty ring slots. One instance sits between each client (core, memory controller, host interface) and the ring.

## Interface
Parameters:
- DATA_W, 512, payload width
- ADDR_W, 36, address width
- ID_W, 4, packet destination-ID width
- TYPE_W, 3, packet-type width
- NODE_ID, 0, this stop's ID; ring packets with id equal to NODE_ID are ejected here
- INJ_DEPTH, 4, injection FIFO depth (>=2, power of two)

Ports (PKT = ADDR_W+DATA_W+ID_W+TYPE_W bits, packed {addr, data, id, type}, addr at MSBs):
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ring_in_valid  in  1  upstream slot occupied
- ring_in_pkt  in  PKT  upstream slot contents
- ring_out_valid  out  1  registered downstream slot occupied
- ring_out_pkt  out  PKT  registered downstream slot contents
- inj_valid  in  1  client offers a packet
- inj_pkt  in  PKT  packet to inject
- inj_ready  out  1  FIFO can accept; transfer on inj_valid && inj_ready
- ej_valid  out  1  ejected packet held
- ej_pkt  out  PKT  ejected packet
- ej_ready  in  1  client consumes; transfer on ej_valid && ej_ready
- inj_count  out  $clog2(INJ_DEPTH+1)  FIFO occupancy

## Operation
- Reset (rst_n low, asynchronous): ring_out_valid=0, ring_out_pkt=0, ej_valid=0, ej_pkt=0, FIFO empty (inj_count=0, pointers 0), inj_ready=1 once reset is released. The FIFO storage array is not reset.
- Eject-register free condition: ej_free = !ej_valid || ej_ready.
- Slot decision, evaluated combinationally every cycle:
  - match = ring_in_valid && (ring_in_pkt.id == NODE_ID).
  - If match && ej_free: capture ring_in_pkt into the eject register. The slot becomes empty.
  - If match && !ej_free: pass the packet through unchanged. It recirculates around the ring and is never dropped.
  - If !ring_in_valid, or the slot was emptied by ejection, and the FIFO is non-empty: pop the FIFO head into ring_out. This is injection.
  - Otherwise: ring_out takes ring_in as-is, valid included.
- Ring traffic always has priority over injection. A valid non-ejected packet is never overwritten.
- If ej_valid && ej_ready and there is no new capture, ej_valid clears.
- FIFO:
  - inj_ready = (inj_count < INJ_DEPTH).
  - A push and a pop in the same cycle leave inj_count unchanged.
  - Pointers wrap modulo INJ_DEPTH.
  - Order is strictly FIFO.
- A packet injected with id==NODE_ID travels the full ring and is ejected here on return. This is legal.

## Timing
- Pass-through latency: ring_in valid at cycle t appears on ring_out at cycle t+1.
- Ejection latency: a matching packet at cycle t gives ej_valid=1 at t+1.
- Back-to-back ejection: throughput is one packet per cycle while ej_ready is held high.
- Injection latency: inj_valid && inj_ready at cycle t makes the packet the FIFO head at t+1. If the slot is free at t+1, ring_out_valid=1 at t+2. There is no bypass path.
- inj_ready depends only on registered count. There is no combinational path from inj_valid or ring_in to inj_ready.
- ej_valid and ej_pkt are registered and stay stable until accepted.
- Reset asserted mid-transfer: all in-flight ring_out, eject and FIFO contents are discarded immediately.

## Test plan
- Reset/pass-through: hold rst_n=0 and check all outputs are 0. Release rst_n and drive id=NODE_ID+1, addr=36'h123, valid=1 at cycle t -> identical packet on ring_out at t+1, ej_valid stays 0.
- Eject with backpressure: two matching packets on consecutive cycles, ej_ready=0 -> first held in ej_pkt, second appears on ring_out (recirculated). Then raise ej_ready -> ej_valid drops after one cycle.
- Inject into gaps: push 4 packets (data 1..4) with ring fully occupied by non-matching traffic -> inj_count=4, inj_ready=0, nothing injected. Then open two empty slots -> data 1 and 2 appear on ring_out in order, inj_count=2.
- Eject-then-inject same cycle: FIFO holds one packet and a matching ring packet arrives with ej_free=1 -> ej_valid=1 and ring_out carries the FIFO packet on the next cycle.
- Simultaneous push and pop at count=2 -> count stays 2. Wrap the pointers through 3*INJ_DEPTH packets -> output order matches input order.
- Asynchronous reset mid-stream: drop rst_n between clock edges while the FIFO holds 3 packets and ej_valid=1 -> outputs go to 0 immediately, without waiting for a clock edge, and inj_count=0.
